// File: rtl/mux_4a1_tx_if.sv
// mux_4a1_tx_if: bus bundle for the TX 4:1 byte serializer.
//   data_0..data_3   parallel byte lanes into the serializer
//   valid_0..valid_3 per-lane valid, sampled together with the data
//   data_000         serialized byte stream
//   valid_000        qualifier for data_000
//   lane_sel         index of the lane currently on data_000
//   frame_start      high while lane 0 is on data_000
//   active           high while the serializer is in RUN
// Modports: master = lane source / stream sink, slave = serializer.
interface mux_4a1_tx_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] data_0;
    logic [BUS_WIDTH-1:0] data_1;
    logic [BUS_WIDTH-1:0] data_2;
    logic [BUS_WIDTH-1:0] data_3;
    logic                 valid_0;
    logic                 valid_1;
    logic                 valid_2;
    logic                 valid_3;
    logic [BUS_WIDTH-1:0] data_000;
    logic                 valid_000;
    logic [1:0]           lane_sel;
    logic                 frame_start;
    logic                 active;

    modport master (
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3,
        input  data_000, valid_000, lane_sel, frame_start, active
    );

    modport slave (
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3,
        output data_000, valid_000, lane_sel, frame_start, active
    );
endinterface

// File: rtl/mux_4a1_tx.sv
// mux_4a1_tx: transmit-side 4:1 byte serializer on the clk_4f domain.
// Four parallel lanes are captured once per 4-cycle frame (phase cnt==3)
// and emitted in order 0,1,2,3 on data_000, one lane per clk_4f cycle.
// Ports:
//   clk_4f   sole clock, rising edge
//   reset_L  asynchronous active-low reset
//   bus      mux_4a1_tx_if.slave (lanes in, serialized stream out)
module mux_4a1_tx #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned IDLE_FRAMES = 2
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    mux_4a1_tx_if.slave bus
);
    localparam logic [4:0] IDLE_LIM = 5'(IDLE_FRAMES);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [1:0]           cnt;
    logic [3:0]           idle_cnt;
    logic [3:0]           idle_cnt_nx;
    logic [BUS_WIDTH-1:0] hold_data [4];
    logic [3:0]           hold_valid;
    logic [BUS_WIDTH-1:0] lane_data [4];
    logic [3:0]           lane_valid;
    logic                 capture;

    logic [BUS_WIDTH-1:0] data_q;
    logic                 valid_q;
    logic [1:0]           sel_q;
    logic                 fs_q;
    logic                 active_q;
    logic [BUS_WIDTH-1:0] data_nx;
    logic                 valid_nx;

    always_comb begin
        lane_data[0] = bus.data_0;
        lane_data[1] = bus.data_1;
        lane_data[2] = bus.data_2;
        lane_data[3] = bus.data_3;
        lane_valid   = {bus.valid_3, bus.valid_2, bus.valid_1, bus.valid_0};
    end

    assign capture = (cnt == 2'd3);

    // State register plus phase counter, hold registers and output register.
    // The slot emitted at each edge is hold[cnt] read before the capture takes
    // effect, so at the capture edge the outgoing lane 3 is still the old frame
    // while lane 0 of the new frame follows on the next edge.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idle_cnt   <= '0;
            hold_valid <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                hold_data[i] <= '0;
            end
            data_q   <= '0;
            valid_q  <= 1'b0;
            sel_q    <= '0;
            fs_q     <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt + 2'd1;
            idle_cnt <= idle_cnt_nx;
            if (capture) begin
                hold_valid <= lane_valid;
                for (int unsigned i = 0; i < 4; i++) begin
                    hold_data[i] <= lane_data[i];
                end
            end
            data_q   <= data_nx;
            valid_q  <= valid_nx;
            sel_q    <= cnt;
            fs_q     <= (cnt == 2'd0);
            // Registered copy of the state: rises with lane 0 of the
            // triggering frame rather than with the capture edge.
            active_q <= (state == ST_RUN);
        end
    end

    // Next-state logic, evaluated only at capture edges.
    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        if (capture) begin
            unique case (state)
                ST_IDLE: begin
                    if (|lane_valid) begin
                        state_nx    = ST_RUN;
                        idle_cnt_nx = '0;
                    end
                end
                ST_RUN: begin
                    if (|lane_valid) begin
                        idle_cnt_nx = '0;
                    end else if (({1'b0, idle_cnt} + 5'd1) >= IDLE_LIM) begin
                        state_nx    = ST_IDLE;
                        idle_cnt_nx = '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt_nx = idle_cnt + 4'd1;
                    end
                end
                default: begin
                    state_nx    = ST_IDLE;
                    idle_cnt_nx = '0;
                end
            endcase
        end
    end

    // Slot content for the lane leaving on this edge.
    always_comb begin
        data_nx  = '0;
        valid_nx = 1'b0;
        if (state == ST_RUN) begin
            if (hold_valid[cnt]) begin
                data_nx  = hold_data[cnt];
                valid_nx = 1'b1;
            end else begin
                data_nx  = data_q;
            end
        end
    end

    assign bus.data_000    = data_q;
    assign bus.valid_000   = valid_q;
    assign bus.lane_sel    = sel_q;
    assign bus.frame_start = fs_q;
    assign bus.active      = active_q;
endmodule
